// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 encryptor.
// FSM encoding, key length and key byte selection.
package arc4_pkg;

  localparam int KEYLEN = 3;

  typedef enum logic [4:0] {
    IDLE,
    LEN_W,
    LEN,
    INIT,
    KSA_RI,
    KSA_J,
    KSA_RJ,
    KSA_WJ,
    KSA_WI,
    PRGA_I,
    PRGA_RI,
    PRGA_J,
    PRGA_RJ,
    PRGA_WJ,
    PRGA_WI,
    PRGA_RP,
    PRGA_XO,
    DONE
  } state_t;

  function automatic logic [7:0] keybyte(
    input logic [8*KEYLEN-1:0] key,
    input logic [1:0]          idx
  );
    return key[8*(KEYLEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/arc4_encrypt_s_mem.sv
// 256x8 single-port RAM holding the ARC4 state array S.
// Registered read: data appears the cycle after addr.
module s_mem (
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] wrdata,
  input  logic       wren,
  output logic [7:0] rddata
);

  logic [7:0] mem [256];

  always_ff @(posedge clk) begin
    if (wren) mem[addr] <= wrdata;
    rddata <= mem[addr];
  end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed plaintext ROM image in,
// ciphertext RAM image out, one S access per cycle.
module arc4_encrypt #(
  parameter int KEYLEN = 3,
  parameter int MSG_AW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                rdy,
  input  logic [8*KEYLEN-1:0] key,
  output logic [MSG_AW-1:0]   pt_addr,
  input  logic [7:0]          pt_rddata,
  output logic [MSG_AW-1:0]   ct_addr,
  output logic [7:0]          ct_wrdata,
  output logic                ct_wren
);
  import arc4_pkg::*;

  state_t              state;
  logic [8*KEYLEN-1:0] key_q;
  logic [7:0]          len;
  logic [7:0]          i;
  logic [7:0]          j;
  logic [7:0]          si;
  logic [7:0]          sj;
  logic [8:0]          k;
  logic [1:0]          km;

  logic [7:0] s_addr;
  logic [7:0] s_wd;
  logic       s_we;
  logic [7:0] s_rd;

  s_mem u_s_mem (
    .clk    (clk),
    .addr   (s_addr),
    .wrdata (s_wd),
    .wren   (s_we),
    .rddata (s_rd)
  );

  // Swap writes S[j] first, then S[i] from the copy of S[j]
  // read beforehand, so i==j leaves the entry unchanged.
  always_comb begin
    s_addr = i;
    s_wd   = i;
    s_we   = 1'b0;
    case (state)
      INIT: s_we = 1'b1;
      KSA_RJ, PRGA_RJ: s_addr = j;
      KSA_WJ, PRGA_WJ: begin
        s_addr = j;
        s_wd   = si;
        s_we   = 1'b1;
      end
      KSA_WI, PRGA_WI: begin
        s_addr = i;
        s_wd   = sj;
        s_we   = 1'b1;
      end
      PRGA_RP: s_addr = si + sj;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      ct_wren   <= 1'b0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      pt_addr   <= '0;
      key_q     <= '0;
      len       <= '0;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      k         <= '0;
      km        <= '0;
    end else begin
      ct_wren <= 1'b0;
      case (state)
        IDLE: if (en) begin
          key_q   <= key;
          rdy     <= 1'b0;
          pt_addr <= '0;
          state   <= LEN_W;
        end
        LEN_W: state <= LEN;
        LEN: begin
          len       <= pt_rddata;
          ct_wren   <= 1'b1;
          ct_addr   <= '0;
          ct_wrdata <= pt_rddata;
          i         <= '0;
          state     <= INIT;
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hff) begin
            j     <= '0;
            km    <= '0;
            state <= KSA_RI;
          end
        end
        KSA_RI: state <= KSA_J;
        KSA_J: begin
          si    <= s_rd;
          j     <= j + s_rd + keybyte(key_q, km);
          state <= KSA_RJ;
        end
        KSA_RJ: state <= KSA_WJ;
        KSA_WJ: begin
          sj    <= s_rd;
          state <= KSA_WI;
        end
        KSA_WI: begin
          i  <= i + 8'd1;
          km <= (km == 2'd2) ? 2'd0 : km + 2'd1;
          if (i == 8'hff) begin
            j     <= '0;
            k     <= 9'd1;
            state <= (len == 8'd0) ? DONE : PRGA_I;
          end else begin
            state <= KSA_RI;
          end
        end
        PRGA_I: begin
          i       <= i + 8'd1;
          pt_addr <= MSG_AW'(k);
          state   <= PRGA_RI;
        end
        PRGA_RI: state <= PRGA_J;
        PRGA_J: begin
          si    <= s_rd;
          j     <= j + s_rd;
          state <= PRGA_RJ;
        end
        PRGA_RJ: state <= PRGA_WJ;
        PRGA_WJ: begin
          sj    <= s_rd;
          state <= PRGA_WI;
        end
        PRGA_WI: state <= PRGA_RP;
        PRGA_RP: state <= PRGA_XO;
        PRGA_XO: begin
          ct_wren   <= 1'b1;
          ct_addr   <= MSG_AW'(k);
          ct_wrdata <= pt_rddata ^ s_rd;
          k         <= k + 9'd1;
          state     <= (k == {1'b0, len}) ? DONE : PRGA_I;
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt against a software RC4 model
// with behavioural plaintext ROM and ciphertext RAM.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;

  logic [7:0] rom  [256];
  logic [7:0] ram  [256];
  logic [7:0] expc [256];
  logic [7:0] orig [256];
  logic [7:0] wq [$];
  logic [7:0] kv [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8,
                          8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] kp [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E,
                         8'h74, 8'h65, 8'h78, 8'h74};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arc4_encrypt #(.KEYLEN(3), .MSG_AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  always @(posedge clk) pt_rddata <= rom[pt_addr];

  always @(posedge clk)
    if (ct_wren) begin
      ram[ct_addr] <= ct_wrdata;
      wq.push_back(ct_addr);
    end

  task automatic model(input logic [23:0] k);
    int s [256];
    int kb [3];
    int i, j, t, len;
    kb[0] = int'(k[23:16]);
    kb[1] = int'(k[15:8]);
    kb[2] = int'(k[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(rom[0]);
    expc[0] = rom[0];
    i = 0;
    j = 0;
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      expc[n] = rom[n] ^ 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic load_known();
    rom[0] = 8'd9;
    for (int n = 0; n < 9; n++) rom[n+1] = kp[n];
    for (int n = 10; n < 256; n++) rom[n] = 8'($urandom);
  endtask

  task automatic load_rand(input int len);
    rom[0] = 8'(len);
    for (int n = 1; n < 256; n++) rom[n] = 8'($urandom);
  endtask

  task automatic run(input logic [23:0] k, output int cyc);
    wq.delete();
    en  = 1'b1;
    key = k;
    @(posedge clk);
    @(negedge clk);
    en  = 1'b0;
    key = 24'($urandom);
    cyc = 1;
    while (!rdy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!rdy) begin
      n_bad++;
      $display("FAIL run_timeout rdy=%b required 1", rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    key = '0;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (rdy !== 1'b1) begin
      n_bad++; $display("FAIL reset_rdy got %b want 1", rdy);
    end
    if (ct_wren !== 1'b0) begin
      n_bad++; $display("FAIL reset_wren got %b want 0", ct_wren);
    end
    if (ct_addr !== 8'h00) begin
      n_bad++; $display("FAIL reset_ct_addr got %h want 00", ct_addr);
    end
    if (ct_wrdata !== 8'h00) begin
      n_bad++; $display("FAIL reset_wrdata got %h want 00", ct_wrdata);
    end
    if (pt_addr !== 8'h00) begin
      n_bad++; $display("FAIL reset_pt_addr got %h want 00", pt_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++; $display("FAIL reset_rdy_after got %b want 1", rdy);
    end
  endtask

  task automatic test_known(input string tag);
    int cyc;
    load_known();
    run(24'h4B6579, cyc);
    for (int n = 0; n < 10; n++) begin
      n_cmp++;
      if (ram[n] !== kv[n]) begin
        n_bad++;
        $display("FAIL %s ct[%0d] got %h want %h", tag, n, ram[n], kv[n]);
      end
    end
    n_cmp++;
    if (wq.size() != 10) begin
      n_bad++;
      $display("FAIL %s wren_count got %0d want 10", tag, wq.size());
    end
    n_cmp++;
    if (cyc > 1796 + 9*9) begin
      n_bad++;
      $display("FAIL %s cycles got %0d want <= %0d", tag, cyc, 1796 + 81);
    end
  endtask

  task automatic test_round_trip();
    int cyc;
    for (int n = 0; n < 256; n++) orig[n] = rom[n];
    for (int n = 0; n < 10; n++) rom[n] = ram[n];
    run(24'h4B6579, cyc);
    for (int n = 0; n < 10; n++) begin
      n_cmp++;
      if (ram[n] !== orig[n]) begin
        n_bad++;
        $display("FAIL round_trip ct[%0d] got %h want %h", n, ram[n], orig[n]);
      end
    end
  endtask

  task automatic test_zero_len();
    int cyc;
    load_rand(0);
    ram[0] = 8'hFF;
    ram[1] = 8'h5A;
    run(24'($urandom), cyc);
    n_cmp += 4;
    if (ram[0] !== 8'h00) begin
      n_bad++; $display("FAIL zero_ct0 got %h want 00", ram[0]);
    end
    if (ram[1] !== 8'h5A) begin
      n_bad++; $display("FAIL zero_ct1 got %h want 5a", ram[1]);
    end
    if (wq.size() != 1) begin
      n_bad++; $display("FAIL zero_writes got %0d want 1", wq.size());
    end
    if (cyc > 1800) begin
      n_bad++; $display("FAIL zero_cycles got %0d want <= 1800", cyc);
    end
  endtask

  task automatic test_random();
    int cyc, len, bad;
    logic [23:0] k;
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 40);
      k = 24'($urandom);
      load_rand(len);
      model(k);
      run(k, cyc);
      bad = 0;
      for (int n = 0; n <= len; n++)
        if (ram[n] !== expc[n]) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL random key=%h len=%0d bad_bytes got %0d want 0", k, len, bad);
      end
      n_cmp++;
      if (cyc > 1796 + 9*len) begin
        n_bad++;
        $display("FAIL random_cycles got %0d want <= %0d", cyc, 1796 + 9*len);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, len, bad;
    logic [23:0] k;
    for (int r = 0; r < 2; r++) begin
      len = $urandom_range(1, 20);
      k = 24'($urandom);
      load_rand(len);
      model(k);
      run(k, cyc);
      bad = 0;
      for (int n = 0; n <= len; n++)
        if (ram[n] !== expc[n]) bad++;
      for (int x = 0; x < wq.size(); x++)
        if (wq[x] !== 8'(x)) bad++;
      n_cmp++;
      if (bad != 0 || wq.size() != len + 1) begin
        n_bad++;
        $display("FAIL b2b run=%0d bad got %0d writes %0d want 0 and %0d",
                 r, bad, wq.size(), len + 1);
      end
    end
  endtask

  task automatic test_busy();
    int cyc, len, bad;
    logic [23:0] k;
    len = 12;
    k = 24'($urandom);
    load_rand(len);
    model(k);
    wq.delete();
    en  = 1'b1;
    key = k;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!rdy) begin
        en  = 1'b1;
        key = 24'($urandom);
      end
    end while (!rdy && cyc < 5000);
    en = 1'b0;
    bad = 0;
    for (int n = 0; n <= len; n++)
      if (ram[n] !== expc[n]) bad++;
    n_cmp += 3;
    if (bad != 0) begin
      n_bad++; $display("FAIL busy bad_bytes got %0d want 0", bad);
    end
    if (wq.size() != len + 1) begin
      n_bad++; $display("FAIL busy writes got %0d want %0d", wq.size(), len + 1);
    end
    if (cyc > 1796 + 9*len) begin
      n_bad++; $display("FAIL busy cycles got %0d want <= %0d", cyc, 1796 + 9*len);
    end
    @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b1 || wq.size() != len + 1) begin
      n_bad++;
      $display("FAIL busy_restart rdy=%b writes=%0d want 1 and %0d", rdy, wq.size(), len + 1);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    load_known();
    wq.delete();
    en  = 1'b1;
    key = 24'h4B6579;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    t = 0;
    while (wq.size() < 4 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (wq.size() != 4) begin
      n_bad++; $display("FAIL rst_mid_reach got %0d writes want 4", wq.size());
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ct_wren !== 1'b0) begin
        n_bad++; $display("FAIL rst_mid_wren cyc=%0d got %b want 0", c, ct_wren);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (rdy !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_rdy got %b want 1", rdy);
    end
    if (wq.size() != 4) begin
      n_bad++; $display("FAIL rst_mid_writes got %0d want 4", wq.size());
    end
    for (int n = 0; n < 10; n++) ram[n] = 8'h00;
    test_known("rst_rerun");
  endtask

  task automatic test_max_len();
    int cyc, bad, z;
    rom[0] = 8'd255;
    for (int n = 1; n < 256; n++) rom[n] = 8'h00;
    model(24'h000018);
    run(24'h000018, cyc);
    bad = 0;
    for (int n = 0; n < 256; n++)
      if (ram[n] !== expc[n]) bad++;
    z = 0;
    for (int x = 0; x < wq.size(); x++)
      if (wq[x] == 8'h00) z++;
    n_cmp += 4;
    if (bad != 0) begin
      n_bad++; $display("FAIL max_len bad_bytes got %0d want 0", bad);
    end
    if (wq.size() != 256) begin
      n_bad++; $display("FAIL max_len writes got %0d want 256", wq.size());
    end
    if (z != 1) begin
      n_bad++; $display("FAIL max_len addr0_writes got %0d want 1", z);
    end
    if (cyc > 1796 + 9*255) begin
      n_bad++; $display("FAIL max_len cycles got %0d want <= %0d", cyc, 1796 + 9*255);
    end
  endtask

  initial begin
    test_reset();
    test_known("known");
    test_round_trip();
    test_zero_len();
    test_random();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
